sim_bus_responder: RTL and testbench

- Parametrised word-addressed memory slave for CPU benches; answers one naive_mips bus port (ibus or dbus).
- Replaces hand-written per-bench wait-request loops with one reusable block.
- Supports reads and byte-enabled writes, and three latency modes (fixed, LFSR-random, alternating).
- Flags protocol violations: request dropped or changed while stalled.

---
 rtl/sim_bus_pkg.sv | 34 +++
 rtl/sim_lfsr16.sv | 24 ++
 rtl/sim_bus_responder.sv | 138 +++++++++++++
 tb/tb_sim_bus_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sim_bus_pkg.sv
// Shared types for the simulation bus responder: latency modes, error codes,
// FSM states, and the LFSR feedback taps.
package sim_bus_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_RANDOM = 2'd1,
        MODE_ALT    = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_DROP   = 2'd1,
        ERR_CHANGE = 2'd2,
        ERR_ROM    = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Feedback taps 16,14,13,11 of a left-shifting Fibonacci LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [31:0] address;
        logic        write;
        logic [31:0] wrdata;
        logic [3:0]  byteenable;
    } req_t;

endpackage

// File: rtl/sim_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per enabled cycle.
// SEED must be nonzero or the sequence locks up at zero.
module sim_lfsr16
    import sim_bus_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (en) begin
            value <= {value[14:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/sim_bus_responder.sv
// Word-addressed memory slave for CPU benches: answers one naive_mips bus port
// with configurable stall latency and flags requests dropped or changed mid-stall.
module sim_bus_responder
    import sim_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned MAX_WAIT    = 7,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter bit          WRITABLE    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic [31:0] bus_address,
    input  logic [3:0]  bus_byteenable,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_wrdata,
    output logic [31:0] bus_rddata,
    output logic        bus_stall,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [31:0] access_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    state_e                state, state_next;
    err_e                  err_next;
    req_t                  lat;
    logic [31:0]           cnt;
    logic [31:0]           load_len;
    logic                  toggle;
    logic [15:0]           lfsr_value;
    logic                  req, accept, changed;
    logic [ADDR_WIDTH-1:0] cur_idx, lat_idx, rd_idx;
    logic                  unused_lfsr_bits;

    assign req     = bus_read | bus_write;
    assign accept  = (state == IDLE) && req;
    assign cur_idx = bus_address[ADDR_WIDTH+1:2];
    assign lat_idx = lat.address[ADDR_WIDTH+1:2];
    // A zero-latency request enters RESP before its address has been latched.
    assign rd_idx  = (state == IDLE) ? cur_idx : lat_idx;
    assign changed = (bus_address != lat.address) || (bus_write != lat.write);
    assign unused_lfsr_bits = &{1'b0, lfsr_value[15:8]};

    sim_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .value (lfsr_value)
    );

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        load_len = 32'(WAIT_CYCLES);
        case (mode)
            MODE_RANDOM: load_len = {24'd0, lfsr_value[7:0]} % (MAX_WAIT + 1);
            MODE_ALT:    load_len = toggle ? 32'(WAIT_CYCLES) : 32'd0;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_next   = ERR_NONE;
        unique case (state)
            IDLE: begin
                if (req) state_next = (load_len != 32'd0) ? WAIT : RESP;
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                    err_next   = ERR_DROP;
                end else begin
                    if (changed)        err_next   = ERR_CHANGE;
                    if (cnt == 32'd1)   state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                if (lat.write && !WRITABLE) err_next = ERR_ROM;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus_stall = rst_n && req && (state != RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat          <= '0;
            cnt          <= '0;
            toggle       <= 1'b0;
            bus_rddata   <= '0;
            err_valid    <= 1'b0;
            err_code     <= ERR_NONE;
            access_count <= '0;
        end else begin
            err_valid <= (err_next != ERR_NONE);
            err_code  <= err_next;
            if (accept) begin
                lat.address    <= bus_address;
                lat.write      <= bus_write;
                lat.wrdata     <= bus_wrdata;
                lat.byteenable <= bus_byteenable;
                cnt            <= load_len;
                if (mode == MODE_ALT) toggle <= ~toggle;
            end else if (state == WAIT) begin
                cnt <= cnt - 32'd1;
            end
            if (state_next == RESP && state != RESP) bus_rddata <= mem[rd_idx];
            if (state == RESP) access_count <= access_count + 32'd1;
        end
    end

    // NOTE: memory is deliberately not reset; contents survive rst_n and the
    // array maps onto plain RAM. Reset only blocks the commit.
    always_ff @(posedge clk) begin
        if (rst_n && state == RESP && lat.write && WRITABLE) begin
            for (int b = 0; b < 4; b++) begin
                if (lat.byteenable[b]) mem[lat_idx][8*b +: 8] <= lat.wrdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sim_bus_responder.sv
// Directed bench for sim_bus_responder: latency modes, byte-enabled writes,
// protocol-error pulses, reset behaviour and LFSR-driven random stalls.
module tb_sim_bus_responder;
    import sim_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = MODE_FIXED;
    logic [31:0] bus_address = '0;
    logic [3:0]  bus_byteenable = '0;
    logic        bus_read = 1'b0;
    logic        bus_write = 1'b0;
    logic [31:0] bus_wrdata = '0;
    logic [31:0] bus_rddata, rom_rddata;
    logic        bus_stall, rom_stall;
    logic        err_valid, rom_err_valid;
    logic [1:0]  err_code, rom_err_code;
    logic [31:0] access_count, rom_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    sim_bus_responder #(
        .ADDR_WIDTH (11), .WAIT_CYCLES (3), .MAX_WAIT (7),
        .LFSR_SEED (16'hACE1), .WRITABLE (1'b1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .mode (mode),
        .bus_address (bus_address), .bus_byteenable (bus_byteenable),
        .bus_read (bus_read), .bus_write (bus_write), .bus_wrdata (bus_wrdata),
        .bus_rddata (bus_rddata), .bus_stall (bus_stall),
        .err_valid (err_valid), .err_code (err_code), .access_count (access_count)
    );

    // Read-only twin sharing every input, so it stays cycle-aligned with dut.
    sim_bus_responder #(
        .ADDR_WIDTH (11), .WAIT_CYCLES (3), .MAX_WAIT (7),
        .LFSR_SEED (16'hACE1), .WRITABLE (1'b0)
    ) rom_dut (
        .clk (clk), .rst_n (rst_n), .mode (mode),
        .bus_address (bus_address), .bus_byteenable (bus_byteenable),
        .bus_read (bus_read), .bus_write (bus_write), .bus_wrdata (bus_wrdata),
        .bus_rddata (rom_rddata), .bus_stall (rom_stall),
        .err_valid (rom_err_valid), .err_code (rom_err_code), .access_count (rom_count)
    );

    // Called just after a negedge with the FSM idle; returns one negedge after RESP.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output int stalls, output logic [31:0] rd);
        bus_address = addr; bus_write = wr; bus_read = ~wr;
        bus_wrdata = data; bus_byteenable = be;
        stalls = 0;
        #1;
        while (bus_stall === 1'b1 && stalls < 50) begin
            stalls++;
            @(negedge clk); #1;
        end
        rd = bus_rddata;
        bus_read = 1'b0; bus_write = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_read = 1'b1; bus_address = 32'h10;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", bus_stall); end
        checks++; if (bus_rddata !== 32'd0) begin errors++; $display("FAIL reset_rddata got=%h want=0", bus_rddata); end
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got=%b want=0", err_valid); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got=%0d want=0", err_code); end
        checks++; if (access_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", access_count); end
        bus_read = 1'b0; rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_fixed_read();
        int s; logic [31:0] rd;
        do_req(1'b1, 32'h10, 32'h2402_0001, 4'hF, s, rd);
        checks++; if (s != 4) begin errors++; $display("FAIL fixed_write_stalls got=%0d want=4", s); end
        do_req(1'b1, 32'h14, 32'hCAFE_F00D, 4'hF, s, rd);
        do_req(1'b1, 32'h20, 32'h1122_3344, 4'hF, s, rd);
        exp_count += 3;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, s, rd);
        exp_count++;
        checks++; if (s != 4) begin errors++; $display("FAIL fixed_read_stalls got=%0d want=4", s); end
        checks++; if (rd !== 32'h2402_0001) begin errors++; $display("FAIL fixed_read_data got=%h want=24020001", rd); end
        checks++; if (access_count !== 32'(exp_count)) begin errors++; $display("FAIL fixed_count got=%0d want=%0d", access_count, exp_count); end
    endtask

    task automatic test_byte_enable();
        int s; logic [31:0] rd;
        do_req(1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0101, s, rd);
        exp_count++;
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL be_ram_err got=%b want=0", err_valid); end
        checks++; if (rom_err_valid !== 1'b1 || rom_err_code !== 2'd3) begin
            errors++; $display("FAIL rom_write_err got=%b/%0d want=1/3", rom_err_valid, rom_err_code); end
        checks++; if (rom_count !== 32'(exp_count)) begin errors++; $display("FAIL rom_count got=%0d want=%0d", rom_count, exp_count); end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, s, rd);
        exp_count++;
        checks++; if (rd !== 32'h11AD_33EF) begin errors++; $display("FAIL be_merge got=%h want=11ad33ef", rd); end
    endtask

    task automatic test_drop();
        int s; logic [31:0] rd;
        bus_address = 32'h10; bus_read = 1'b1;
        #1;
        checks++; if (bus_stall !== 1'b1) begin errors++; $display("FAIL drop_first_stall got=%b want=1", bus_stall); end
        @(negedge clk); #1;
        bus_read = 1'b0;
        #1;
        checks++; if (bus_stall !== 1'b0) begin errors++; $display("FAIL drop_stall_low got=%b want=0", bus_stall); end
        @(negedge clk); #1;
        checks++; if (err_valid !== 1'b1 || err_code !== 2'd1) begin
            errors++; $display("FAIL drop_err got=%b/%0d want=1/1", err_valid, err_code); end
        checks++; if (access_count !== 32'(exp_count)) begin errors++; $display("FAIL drop_count got=%0d want=%0d", access_count, exp_count); end
        @(negedge clk); #1;
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL drop_pulse_width got=%b want=0", err_valid); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, s, rd);
        exp_count++;
        checks++; if (s != 4 || rd !== 32'h2402_0001) begin
            errors++; $display("FAIL drop_recover got=%0d/%h want=4/24020001", s, rd); end
    endtask

    task automatic test_change();
        int s = 0; logic saw = 1'b0;
        bus_address = 32'h10; bus_read = 1'b1;
        #1;
        while (bus_stall === 1'b1 && s < 50) begin
            s++;
            if (s == 2) bus_address = 32'h14;
            @(negedge clk); #1;
            if (err_valid === 1'b1 && err_code === 2'd2) saw = 1'b1;
        end
        checks++; if (!saw) begin errors++; $display("FAIL change_err got=none want=code2"); end
        checks++; if (s != 4) begin errors++; $display("FAIL change_stalls got=%0d want=4", s); end
        checks++; if (bus_rddata !== 32'h2402_0001) begin errors++; $display("FAIL change_data got=%h want=24020001", bus_rddata); end
        bus_read = 1'b0;
        @(negedge clk); #1;
        exp_count++;
        checks++; if (access_count !== 32'(exp_count)) begin errors++; $display("FAIL change_count got=%0d want=%0d", access_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        int s = 0;
        bus_address = 32'h10; bus_read = 1'b1;
        #1;
        while (bus_stall === 1'b1 && s < 50) begin s++; @(negedge clk); #1; end
        checks++; if (bus_rddata !== 32'h2402_0001) begin errors++; $display("FAIL b2b_first got=%h want=24020001", bus_rddata); end
        bus_address = 32'h20;
        @(negedge clk); #1;
        s = 0;
        while (bus_stall === 1'b1 && s < 50) begin s++; @(negedge clk); #1; end
        checks++; if (s != 4) begin errors++; $display("FAIL b2b_second_stalls got=%0d want=4", s); end
        checks++; if (bus_rddata !== 32'h11AD_33EF) begin errors++; $display("FAIL b2b_second got=%h want=11ad33ef", bus_rddata); end
        bus_read = 1'b0;
        @(negedge clk); #1;
        exp_count += 2;
        checks++; if (access_count !== 32'(exp_count)) begin errors++; $display("FAIL b2b_count got=%0d want=%0d", access_count, exp_count); end
    endtask

    task automatic test_alt();
        int s; logic [31:0] rd;
        int want [3] = '{1, 4, 1};
        mode = MODE_ALT;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 32'h14, 32'h0, 4'h0, s, rd);
            exp_count++;
            checks++; if (s != want[i]) begin errors++; $display("FAIL alt_stalls[%0d] got=%0d want=%0d", i, s, want[i]); end
        end
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL alt_data got=%h want=cafef00d", rd); end
        mode = MODE_FIXED;
    endtask

    task automatic test_reset_mid_write();
        int s; logic [31:0] rd;
        bus_address = 32'h20; bus_write = 1'b1; bus_wrdata = 32'h0; bus_byteenable = 4'hF;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%b want=0", bus_stall); end
        @(negedge clk); #1;
        checks++; if (access_count !== 32'd0) begin errors++; $display("FAIL rst_mid_count got=%0d want=0", access_count); end
        rst_n = 1'b1; bus_write = 1'b0;
        @(negedge clk); #1;
        do_req(1'b0, 32'h20, 32'h0, 4'h0, s, rd);
        checks++; if (rd !== 32'h11AD_33EF) begin errors++; $display("FAIL rst_mid_data got=%h want=11ad33ef", rd); end
        checks++; if (access_count !== 32'd1) begin errors++; $display("FAIL rst_mid_after got=%0d want=1", access_count); end
    endtask

    task automatic test_random();
        int s, want; logic [31:0] rd;
        logic [15:0] l = 16'hACE1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1; mode = MODE_RANDOM;
        for (int i = 0; i < 1000; i++) begin
            want = 1 + (int'(l[7:0]) % 8);
            do_req(1'b0, 32'($urandom_range(0, 2047)) << 2, 32'h0, 4'h0, s, rd);
            checks++; if (s != want) begin errors++; $display("FAIL rand_stalls[%0d] got=%0d want=%0d", i, s, want); end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        checks++; if (access_count !== 32'd1000) begin errors++; $display("FAIL rand_count got=%0d want=1000", access_count); end
        mode = MODE_FIXED;
    endtask

    initial begin
        test_reset();
        test_fixed_read();
        test_byte_enable();
        test_drop();
        test_change();
        test_back_to_back();
        test_alt();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
